ksa_shuffle_fsm: RTL and testbench
==================================

# ksa_shuffle_fsm

Key-scheduling (shuffle) worker for the RC4 datapath. It starts on a one-cycle `start` pulse from the top-level sequencer, after the init worker has left S[n] = n in the 256x8 S-memory. For i = 0..255 it computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] and S[j]. It then returns a one-cycle `finish` pulse. Its address, data and write-enable outputs feed the sequencer's memory-port mux, which routes them to the single-port S-memory while this block is selected.

## Interface
- `KEY_BYTES`, default 3: secret-key length in bytes; legal values 1..32.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  start request; sampled only in IDLE.
- `secret_key`  in  8*KEY_BYTES  key. Byte 0 is `secret_key[8*KEY_BYTES-1 -: 8]` (MSB-first). Must be stable from `start` until `finish`.
- `q`  in  8  S-memory read data.
- `address`  out  8  S-memory address.
- `data`  out  8  S-memory write data.
- `wren`  out  1  S-memory write enable.
- `finish`  out  1  one-cycle done pulse.

## Operation
- Internal registers:
  - `i` (8 b), `j` (8 b), `k` (key-byte index, 0..KEY_BYTES-1).
  - `si`, `sj` (8 b each): latched S values.
- All outputs are registered (decoded from state and registers). No combinational path from inputs to outputs.
- Memory contract: synchronous read. `q` is valid the cycle after `address` is sampled and stays valid while `address` is unchanged.
- States and transitions:
  - IDLE: outputs 0. If `start`=1: clear i, j, k; go to RD_SI.
  - RD_SI: `address`=i, `wren`=0; go to WAIT_SI.
  - WAIT_SI: hold `address`=i; go to LATCH_SI.
  - LATCH_SI: `si`<=q; j <= (j + q + keybyte[k]) mod 256; go to RD_SJ.
  - RD_SJ: `address`=j (the updated j); go to WAIT_SJ.
  - WAIT_SJ: hold; go to LATCH_SJ.
  - LATCH_SJ: `sj`<=q; go to WR_SI.
  - WR_SI: `address`=i, `data`=sj, `wren`=1; go to WR_SJ.
  - WR_SJ: `address`=j, `data`=si, `wren`=1; go to INC.
  - INC: `wren`=0.
    - If i==255: go to DONE.
    - Else: i<=i+1; k<=(k==KEY_BYTES-1)?0:k+1; go to RD_SI.
  - DONE: `finish`=1; go to IDLE.
- Arithmetic: all 8-bit additions wrap modulo 256; carries are discarded.
- Key index: `k` is a wrapping counter, not a divider. `k` equals i mod KEY_BYTES at all times.
- `start` is ignored outside IDLE. If `start` is held high, a new run begins immediately after the DONE cycle; this is the sequencer's responsibility to avoid.

## Timing
- Reset values: `address`=0, `data`=0, `wren`=0, `finish`=0, state IDLE, all internal registers 0.
- Per-iteration cost: 9 cycles. Full run: 2304 cycles from the first RD_SI to the last INC.
- Start-to-finish latency: `start` sampled high at edge E. RD_SI occupies the cycle after E. `finish` is high exactly in cycle E+2305 (counting the cycle after E as E+1), for one cycle.
- Write count: exactly 512 `wren` cycles per run, each exactly one cycle wide. There are never two consecutive writes to different iterations without an INC between them.
- Boundary i==j: both writes target the same address with the same value S[i]; the final S[i] is unchanged. This is required behaviour, not an error.
- Wrap-around: when i==255, INC goes to DONE without incrementing, so i does not wrap to 0 within a run.
- Reset mid-operation: `reset_n` low forces IDLE and all outputs to 0 asynchronously, and no further writes occur. Memory contents are left partially shuffled. The next `start` restarts from i=0, j=0.

## Test plan
- Reset: drive `reset_n`=0 mid-cycle -> `address`, `data`, `wren` and `finish` are all 0 immediately; after release, state is IDLE and outputs stay 0 with `start`=0.
- Memory preloaded with S[n]=n, KEY_BYTES=3, key 24'h000249, `start` pulse:
  - Iteration 0 writes addr 0 data 0 twice.
  - Iteration 1 (j=0+1+2=3) writes addr 1 data 3, then addr 3 data 1.
  - Final memory matches the software KSA model.
  - `finish` arrives at cycle 2305.
- Key 24'h000000 with S[n]=n -> iteration 0 exercises i==j (addr 0 written twice with 0); full run matches the model; 512 `wren` pulses counted.
- `start` held high for 10 cycles at launch, plus extra `start` pulses at iterations 5 and 200 -> exactly one run; one `finish` pulse; no disturbance to the address/write sequence.
- `reset_n` pulsed low during iteration 100 WR_SI -> `wren` drops at once and no further writes occur; a fresh `start` produces a write sequence beginning at iteration 0 with j=0.
- KEY_BYTES=1, key 8'hFF -> `k` stays 0 and every j update adds 0xFF mod 256; final memory matches the model.

Source files
------------

// File: rtl/ksa_shuffle_fsm_if.sv
// rtl/ksa_shuffle_fsm_if.sv - S-memory port between the KSA shuffle worker and the memory mux
//
// Purpose: bundles the single-port S-memory signals driven by the shuffle worker.
// Signals:
//   address  8  S-memory address          (master -> slave)
//   data     8  S-memory write data       (master -> slave)
//   wren     1  S-memory write enable     (master -> slave)
//   q        8  S-memory read data        (slave -> master), synchronous read
interface ksa_shuffle_fsm_if;
   logic [7:0] address;
   logic [7:0] data;
   logic       wren;
   logic [7:0] q;

   modport master (output address, output data, output wren, input q);
   modport slave  (input address, input data, input wren, output q);
endinterface

// File: rtl/ksa_shuffle_fsm.sv
// rtl/ksa_shuffle_fsm.sv - RC4 key-scheduling (shuffle) worker
//
// Purpose: on a start pulse, runs the RC4 KSA over a 256x8 S-memory that
// already holds S[n]=n: for i = 0..255, j += S[i] + key[i mod KEY_BYTES],
// then swap S[i] and S[j]. Ends with a one-cycle finish pulse.
// Ports:
//   clk         1             rising-edge clock
//   reset_n     1             asynchronous active-low reset
//   start       1             run request, sampled only in IDLE
//   secret_key  8*KEY_BYTES   key, byte 0 in the most significant byte
//   finish      1             one-cycle done pulse
//   mem         interface     S-memory port (address/data/wren out, q in)
module ksa_shuffle_fsm #(
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   output logic                   finish,
   ksa_shuffle_fsm_if.master      mem
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE, RD_SI, WAIT_SI, LATCH_SI, RD_SJ, WAIT_SJ, LATCH_SJ,
      WR_SI, WR_SJ, INC, DONE
   } state_t;

   state_t        state, state_d;
   logic [7:0]    i, j, si, sj;
   logic [7:0]    i_d, j_d, si_d, sj_d;
   logic [KW-1:0] k, k_d;
   logic [7:0]    key_byte;

   logic [7:0]    address_r, data_r, address_d, data_d;
   logic          wren_r, wren_d, finish_r, finish_d;

   // Key byte k, counted from the most significant byte of secret_key.
   always_comb begin
      key_byte = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (k == KW'(b)) begin
            key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
         end
      end
   end

   // State and datapath registers, plus the registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         si        <= '0;
         sj        <= '0;
         address_r <= '0;
         data_r    <= '0;
         wren_r    <= 1'b0;
         finish_r  <= 1'b0;
      end else begin
         state     <= state_d;
         i         <= i_d;
         j         <= j_d;
         k         <= k_d;
         si        <= si_d;
         sj        <= sj_d;
         address_r <= address_d;
         data_r    <= data_d;
         wren_r    <= wren_d;
         finish_r  <= finish_d;
      end
   end

   // Next state and next datapath values.
   always_comb begin
      state_d = state;
      i_d     = i;
      j_d     = j;
      k_d     = k;
      si_d    = si;
      sj_d    = sj;
      case (state)
         IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = RD_SI;
            end
         end
         RD_SI:    state_d = WAIT_SI;
         WAIT_SI:  state_d = LATCH_SI;
         LATCH_SI: begin
            si_d    = mem.q;
            j_d     = j + mem.q + key_byte;
            state_d = RD_SJ;
         end
         RD_SJ:    state_d = WAIT_SJ;
         WAIT_SJ:  state_d = LATCH_SJ;
         LATCH_SJ: begin
            sj_d    = mem.q;
            state_d = WR_SI;
         end
         WR_SI:    state_d = WR_SJ;
         WR_SJ:    state_d = INC;
         INC: begin
            if (i == 8'hFF) begin
               state_d = DONE;
            end else begin
               i_d     = i + 8'd1;
               k_d     = (k == K_LAST) ? '0 : k + KW'(1);
               state_d = RD_SI;
            end
         end
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and next register values so
   // that, once registered, they line up with the state they belong to.
   always_comb begin
      address_d = '0;
      data_d    = '0;
      wren_d    = 1'b0;
      finish_d  = 1'b0;
      case (state_d)
         RD_SI, WAIT_SI, LATCH_SI: address_d = i_d;
         RD_SJ, WAIT_SJ, LATCH_SJ: address_d = j_d;
         WR_SI: begin
            address_d = i_d;
            data_d    = sj_d;
            wren_d    = 1'b1;
         end
         WR_SJ: begin
            address_d = j_d;
            data_d    = si_d;
            wren_d    = 1'b1;
         end
         INC:      address_d = j_d;
         DONE:     finish_d  = 1'b1;
         default:  address_d = '0;
      endcase
   end

   assign mem.address = address_r;
   assign mem.data    = data_r;
   assign mem.wren    = wren_r;
   assign finish      = finish_r;

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// tb/tb_ksa_shuffle_fsm.sv - scoreboard bench for ksa_shuffle_fsm
module tb_ksa_shuffle_fsm;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_a, start_b;
   logic [23:0] key_a;
   logic [7:0]  key_b;
   logic        finish_a, finish_b;
   logic        load_a, load_b;

   always #5 clk = ~clk;

   ksa_shuffle_fsm_if mif_a ();
   ksa_shuffle_fsm_if mif_b ();

   ksa_shuffle_fsm #(.KEY_BYTES(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .secret_key(key_a),
      .finish(finish_a), .mem(mif_a.master)
   );

   ksa_shuffle_fsm #(.KEY_BYTES(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .secret_key(key_b),
      .finish(finish_b), .mem(mif_b.master)
   );

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] model_s [256];

   always @(posedge clk) begin
      if (load_a) begin
         for (int n = 0; n < 256; n++) mem_a[n] <= 8'(n);
      end else if (mif_a.wren) begin
         mem_a[mif_a.address] <= mif_a.data;
      end
      mif_a.q <= mem_a[mif_a.address];
   end

   always @(posedge clk) begin
      if (load_b) begin
         for (int n = 0; n < 256; n++) mem_b[n] <= 8'(n);
      end else if (mif_b.wren) begin
         mem_b[mif_b.address] <= mif_b.data;
      end
      mif_b.q <= mem_b[mif_b.address];
   end

   wr_t exp_a[$], exp_b[$];
   int  fin_a[$], fin_b[$];
   int  tests = 0, fails = 0;
   int  cyc = 0;
   int  wcount_a = 0, fcount_a = 0, log_n_a = 0;
   int  wcount_b = 0, fcount_b = 0;
   wr_t log_a [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Software KSA on model_s; optionally queues the expected write pairs.
   task automatic model_run(input int kb, input logic [255:0] key, input int stop_iter,
                            input bit push, input bit which);
      logic [7:0] jj, t, kbyte;
      jj = 8'd0;
      for (int ii = 0; ii < stop_iter; ii++) begin
         kbyte = key[8*kb-1-8*(ii%kb) -: 8];
         jj = jj + model_s[ii] + kbyte;
         if (push) begin
            if (!which) begin
               exp_a.push_back({8'(ii), model_s[jj]});
               exp_a.push_back({jj, model_s[ii]});
            end else begin
               exp_b.push_back({8'(ii), model_s[jj]});
               exp_b.push_back({jj, model_s[ii]});
            end
         end
         t = model_s[ii];
         model_s[ii] = model_s[jj];
         model_s[jj] = t;
      end
   endtask

   // Monitors: pop expected writes / finish cycles whenever the DUT presents them.
   always @(negedge clk) begin
      wr_t e;
      if (mif_a.wren) begin
         if (log_n_a < 4) begin
            log_a[log_n_a] = {mif_a.address, mif_a.data};
            log_n_a++;
         end
         wcount_a++;
         if (exp_a.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL a_unexpected_write: addr %0d data %0d, no write expected",
                     mif_a.address, mif_a.data);
         end else begin
            e = exp_a.pop_front();
            chk("a_wr_addr", int'(mif_a.address), int'(e.addr));
            chk("a_wr_data", int'(mif_a.data), int'(e.data));
         end
      end
      if (finish_a) begin
         fcount_a++;
         if (fin_a.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL a_unexpected_finish: at cycle %0d, none expected", cyc);
         end else begin
            chk("a_finish_cycle", cyc, fin_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (mif_b.wren) begin
         wcount_b++;
         if (exp_b.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL b_unexpected_write: addr %0d data %0d, no write expected",
                     mif_b.address, mif_b.data);
         end else begin
            e = exp_b.pop_front();
            chk("b_wr_addr", int'(mif_b.address), int'(e.addr));
            chk("b_wr_data", int'(mif_b.data), int'(e.data));
         end
      end
      if (finish_b) begin
         fcount_b++;
         if (fin_b.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL b_unexpected_finish: at cycle %0d, none expected", cyc);
         end else begin
            chk("b_finish_cycle", cyc, fin_b.pop_front());
         end
      end
   end

   task automatic preload(input bit which);
      @(negedge clk);
      if (which) load_b = 1'b1; else load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      for (int n = 0; n < 256; n++) model_s[n] = 8'(n);
   endtask

   task automatic clear_counts();
      wcount_a = 0; fcount_a = 0; log_n_a = 0;
      wcount_b = 0; fcount_b = 0;
   endtask

   // Start held for `hold` edges; finish is due 2305 cycles after the first.
   task automatic launch(input bit which, input int hold);
      @(negedge clk);
      if (which) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk);
      #1;
      if (which) fin_b.push_back(cyc + 2304); else fin_a.push_back(cyc + 2304);
      repeat (hold - 1) @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_finish(input bit which, input string tag);
      int n = 0;
      while ((which ? fcount_b : fcount_a) == 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: no finish within %0d cycles, required one", tag, n);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic check_end(input bit which, input string tag);
      int bad = 0;
      chk({tag, "_pending_writes"}, which ? exp_b.size() : exp_a.size(), 0);
      chk({tag, "_wren_count"}, which ? wcount_b : wcount_a, 512);
      chk({tag, "_finish_count"}, which ? fcount_b : fcount_a, 1);
      for (int n = 0; n < 256; n++) begin
         if ((which ? mem_b[n] : mem_a[n]) != model_s[n]) bad++;
      end
      chk({tag, "_mem_mismatches"}, bad, 0);
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, "_address"}, int'(mif_a.address), 0);
      chk({tag, "_data"}, int'(mif_a.data), 0);
      chk({tag, "_wren"}, int'(mif_a.wren), 0);
      chk({tag, "_finish"}, int'(finish_a), 0);
   endtask

   initial begin
      int n;
      reset_n = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      key_a = '0; key_b = '0;
      load_a = 1'b0; load_b = 1'b0;

      // Reset asserted mid-cycle, then released with start low.
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 chk_idle_a("rst_async");
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk_idle_a("rst_idle");
      end

      // Key 000249 on identity memory.
      key_a = 24'h000249;
      preload(1'b0);
      model_run(3, {232'd0, key_a}, 256, 1'b1, 1'b0);
      clear_counts();
      launch(1'b0, 1);
      wait_finish(1'b0, "k249");
      check_end(1'b0, "k249");
      chk("k249_w0_addr", int'(log_a[0].addr), 0);
      chk("k249_w0_data", int'(log_a[0].data), 0);
      chk("k249_w1_addr", int'(log_a[1].addr), 0);
      chk("k249_w1_data", int'(log_a[1].data), 0);
      chk("k249_w2_addr", int'(log_a[2].addr), 1);
      chk("k249_w2_data", int'(log_a[2].data), 3);
      chk("k249_w3_addr", int'(log_a[3].addr), 3);
      chk("k249_w3_data", int'(log_a[3].data), 1);

      // Zero key: iteration 0 has i == j.
      key_a = 24'h000000;
      preload(1'b0);
      model_run(3, {232'd0, key_a}, 256, 1'b1, 1'b0);
      clear_counts();
      launch(1'b0, 1);
      wait_finish(1'b0, "kzero");
      check_end(1'b0, "kzero");
      chk("kzero_w0_addr", int'(log_a[0].addr), 0);
      chk("kzero_w0_data", int'(log_a[0].data), 0);
      chk("kzero_w1_addr", int'(log_a[1].addr), 0);
      chk("kzero_w1_data", int'(log_a[1].data), 0);

      // Start held 10 cycles, plus stray pulses at iterations 5 and 200.
      key_a = 24'hA53C0F;
      preload(1'b0);
      model_run(3, {232'd0, key_a}, 256, 1'b1, 1'b0);
      clear_counts();
      launch(1'b0, 10);
      n = 0;
      while (wcount_a < 10 && n < 3000) begin @(negedge clk); n++; end
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      n = 0;
      while (wcount_a < 400 && n < 3000) begin @(negedge clk); n++; end
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      wait_finish(1'b0, "hold");
      check_end(1'b0, "hold");

      // Reset during iteration 100 WR_SI, then a fresh run from i=0, j=0.
      key_a = 24'h0A0B0C;
      preload(1'b0);
      model_run(3, {232'd0, key_a}, 256, 1'b1, 1'b0);
      for (int m = 0; m < 256; m++) model_s[m] = 8'(m);
      model_run(3, {232'd0, key_a}, 100, 1'b0, 1'b0);
      clear_counts();
      launch(1'b0, 1);
      n = 0;
      begin
         int seen = 0;
         while (n < 3000) begin
            @(negedge clk);
            n++;
            if (mif_a.wren) begin
               if (seen == 200) break;
               seen++;
            end
         end
      end
      chk("rst_mid_found_iter100", n < 3000 ? 1 : 0, 1);
      #1 reset_n = 1'b0;
      #1 chk_idle_a("rst_mid");
      exp_a.delete();
      fin_a.delete();
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("rst_mid_wren_count", wcount_a, 201);
      begin
         int bad = 0;
         for (int m = 0; m < 256; m++) if (mem_a[m] != model_s[m]) bad++;
         chk("rst_mid_partial_mem", bad, 0);
      end
      model_run(3, {232'd0, key_a}, 256, 1'b1, 1'b0);
      clear_counts();
      launch(1'b0, 1);
      wait_finish(1'b0, "rst_rerun");
      check_end(1'b0, "rst_rerun");

      // Single-byte key FF on the KEY_BYTES=1 instance.
      key_b = 8'hFF;
      preload(1'b1);
      model_run(1, {248'd0, key_b}, 256, 1'b1, 1'b1);
      clear_counts();
      launch(1'b1, 1);
      wait_finish(1'b1, "kb1");
      check_end(1'b1, "kb1");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
